// File: rtl/hybrid_pkg.sv
// -----------------------------------------------------------------------------
// hybrid_pkg
// Shared types and constants for the half-bridge jump sequencer.
//   seq_state_t : sequencer FSM state (3-bit encoding)
//   CNT_W       : width of the dead-time, dwell and jump counters
//   GATE_*      : {gate_hi, gate_lo} encodings
//   gate_of()   : gate pair driven in a given state
// -----------------------------------------------------------------------------
package hybrid_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DEAD_TO_HI = 3'd1,
    ST_DEAD_TO_LO = 3'd2,
    ST_ON_HI      = 3'd3,
    ST_ON_LO      = 3'd4,
    ST_FAULT      = 3'd5
  } seq_state_t;

  // {gate_hi, gate_lo}; there is deliberately no encoding with both bits set.
  localparam logic [1:0] GATE_OFF = 2'b00;
  localparam logic [1:0] GATE_HI  = 2'b10;
  localparam logic [1:0] GATE_LO  = 2'b01;

  function automatic logic [1:0] gate_of(input seq_state_t s);
    case (s)
      ST_ON_HI: return GATE_HI;
      ST_ON_LO: return GATE_LO;
      default:  return GATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/jump_arbiter.sv
// -----------------------------------------------------------------------------
// jump_arbiter
// Combinational fixed-priority arbiter: the lowest-index active request wins.
//   req          [N] : per-requester request valid
//   sigma        [N] : per-requester desired switch state
//   grant_onehot [N] : one-hot winner (all zero when no request)
//   any_req          : at least one request present
//   target_sigma     : desired switch state of the winner (0 when none)
// -----------------------------------------------------------------------------
module jump_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] sigma,
  output logic [N-1:0] grant_onehot,
  output logic         any_req,
  output logic         target_sigma
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    grant_onehot = '0;
    target_sigma = 1'b0;
    any_req      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any_req) begin
        grant_onehot[i] = 1'b1;
        target_sigma    = sigma[i];
        any_req         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hybrid_jump_sequencer.sv
// -----------------------------------------------------------------------------
// hybrid_jump_sequencer
// Drives the half-bridge gate pair from arbitrated jump requests, inserting a
// dead time on every transition and holding each gate for a minimum dwell.
//   i_clk, i_reset      : clock, synchronous active-low reset
//   i_enable            : run enable; low returns to IDLE
//   i_fault             : protection fault, forces FAULT
//   i_req, i_sigma  [N] : per-requester valid and desired switch state
//   o_gate_hi/o_gate_lo : registered gate drives, never both high
//   o_sigma             : committed switch state
//   o_busy              : high in a dead-time state
//   o_grant         [N] : one-cycle one-hot pulse of the accepted requester
//   o_fault_latched     : high in FAULT
//   o_jump_count   [16] : accepted jumps, modulo 2^16
// -----------------------------------------------------------------------------
module hybrid_jump_sequencer
  import hybrid_pkg::*;
#(
  parameter int unsigned DEAD_TIME = 10,
  parameter int unsigned MIN_DWELL = 20,
  parameter int unsigned N         = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_fault,
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_sigma,
  output logic             o_gate_hi,
  output logic             o_gate_lo,
  output logic             o_sigma,
  output logic             o_busy,
  output logic [N-1:0]     o_grant,
  output logic             o_fault_latched,
  output logic [CNT_W-1:0] o_jump_count
);

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] DWELL_SAT = CNT_W'(MIN_DWELL);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] dead_q, dead_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic             sigma_d;
  logic [N-1:0]     grant_d;
  logic             gate_hi_d, gate_lo_d;

  logic [N-1:0]     arb_grant;
  logic             arb_any;
  logic             arb_target;
  logic             accept;

  jump_arbiter #(.N(N)) u_arbiter (
    .req          (i_req),
    .sigma        (i_sigma),
    .grant_onehot (arb_grant),
    .any_req      (arb_any),
    .target_sigma (arb_target)
  );

  always_comb begin
    state_d    = state_q;
    dead_d     = dead_q;
    dwell_d    = dwell_q;
    jump_cnt_d = jump_cnt_q;
    sigma_d    = o_sigma;
    grant_d    = '0;
    accept     = 1'b0;

    // Fault outranks enable, which outranks any request in the same cycle.
    if (i_fault) begin
      state_d = ST_FAULT;
      dead_d  = '0;
      dwell_d = '0;
    end else if (state_q == ST_FAULT) begin
      // Leaving FAULT needs the operator to drop enable as well.
      if (!i_enable) state_d = ST_IDLE;
    end else if (!i_enable) begin
      state_d = ST_IDLE;
      dead_d  = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: accept = arb_any;
        ST_DEAD_TO_HI, ST_DEAD_TO_LO: begin
          if (dead_q == DEAD_LAST) begin
            state_d = (state_q == ST_DEAD_TO_HI) ? ST_ON_HI : ST_ON_LO;
            dead_d  = '0;
            dwell_d = CNT_W'(1);
          end else begin
            dead_d = dead_q + CNT_W'(1);
          end
        end
        ST_ON_HI, ST_ON_LO: begin
          // A request for the state already held is not a jump.
          if (dwell_q == DWELL_SAT && arb_any && arb_target != o_sigma) begin
            accept = 1'b1;
          end else if (dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      grant_d    = arb_grant;
      jump_cnt_d = jump_cnt_q + CNT_W'(1);
      sigma_d    = arb_target;
      state_d    = arb_target ? ST_DEAD_TO_HI : ST_DEAD_TO_LO;
      dead_d     = '0;
      dwell_d    = '0;
    end

    // Gates are decoded from the next state so the pins come straight off flops.
    {gate_hi_d, gate_lo_d} = gate_of(state_d);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!i_reset) begin
      state_q         <= ST_IDLE;
      dead_q          <= '0;
      dwell_q         <= '0;
      jump_cnt_q      <= '0;
      o_sigma         <= 1'b0;
      o_grant         <= '0;
      o_gate_hi       <= 1'b0;
      o_gate_lo       <= 1'b0;
      o_busy          <= 1'b0;
      o_fault_latched <= 1'b0;
    end else begin
      state_q         <= state_d;
      dead_q          <= dead_d;
      dwell_q         <= dwell_d;
      jump_cnt_q      <= jump_cnt_d;
      o_sigma         <= sigma_d;
      o_grant         <= grant_d;
      o_gate_hi       <= gate_hi_d;
      o_gate_lo       <= gate_lo_d;
      o_busy          <= (state_d == ST_DEAD_TO_HI) || (state_d == ST_DEAD_TO_LO);
      o_fault_latched <= (state_d == ST_FAULT);
    end
  end

  assign o_jump_count = jump_cnt_q;

endmodule

// File: tb/tb_hybrid_jump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hybrid_jump_sequencer
// Self-checking bench for hybrid_jump_sequencer (DEAD_TIME=10, MIN_DWELL=20,
// N=2). Each cycle's expected outputs are queued when the inputs are driven
// and popped for comparison one tick after the following rising edge.
// -----------------------------------------------------------------------------
module tb_hybrid_jump_sequencer;

  logic        i_clk    = 1'b0;
  logic        i_reset  = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_fault  = 1'b0;
  logic [1:0]  i_req    = '0;
  logic [1:0]  i_sigma  = '0;
  logic        o_gate_hi, o_gate_lo, o_sigma, o_busy, o_fault_latched;
  logic [1:0]  o_grant;
  logic [15:0] o_jump_count;

  hybrid_jump_sequencer #(.DEAD_TIME(10), .MIN_DWELL(20), .N(2)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_fault         (i_fault),
    .i_req           (i_req),
    .i_sigma         (i_sigma),
    .o_gate_hi       (o_gate_hi),
    .o_gate_lo       (o_gate_lo),
    .o_sigma         (o_sigma),
    .o_busy          (o_busy),
    .o_grant         (o_grant),
    .o_fault_latched (o_fault_latched),
    .o_jump_count    (o_jump_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        hi;
    logic        lo;
    logic        sigma;
    logic        busy;
    logic        fault;
    logic [1:0]  grant;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       flt;
    logic [1:0] req;
    logic [1:0] sig;
    out_t       exp;
  } vec_t;

  out_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   overlap = 1'b0;

  always @(negedge i_clk) if (o_gate_hi && o_gate_lo) overlap = 1'b1;

  function automatic out_t mk(input logic hi, input logic lo, input logic sig,
                              input logic busy, input logic flt,
                              input logic [1:0] gnt, input logic [15:0] cnt);
    out_t o;
    o = '{hi: hi, lo: lo, sigma: sig, busy: busy, fault: flt, grant: gnt, cnt: cnt};
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got hi=%b lo=%b sigma=%b busy=%b fault=%b grant=%b cnt=%h, expected hi=%b lo=%b sigma=%b busy=%b fault=%b grant=%b cnt=%h",
                  name, act.hi, act.lo, act.sigma, act.busy, act.fault, act.grant, act.cnt,
                  exp.hi, exp.lo, exp.sigma, exp.busy, exp.fault, exp.grant, exp.cnt);
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic cyc(input string name, input logic rst, input logic en, input logic flt,
                     input logic [1:0] req, input logic [1:0] sig, input out_t e);
    out_t act;
    @(negedge i_clk);
    i_reset  = rst;
    i_enable = en;
    i_fault  = flt;
    i_req    = req;
    i_sigma  = sig;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    act = '{hi: o_gate_hi, lo: o_gate_lo, sigma: o_sigma, busy: o_busy,
            fault: o_fault_latched, grant: o_grant, cnt: o_jump_count};
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got cnt=%h", name, act.cnt);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{"reset",          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'd0)};
    tbl[1] = '{"idle_no_req",    1'b1, 1'b1, 1'b0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'd0)};
    tbl[2] = '{"idle_enable_lo", 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, mk(0,0,0,0,0,2'b00,16'd0)};
    tbl[3] = '{"idle_fault_req", 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, mk(0,0,0,0,1,2'b00,16'd0)};
    tbl[4] = '{"fault_hold_en",  1'b1, 1'b1, 1'b0, 2'b01, 2'b01, mk(0,0,0,0,1,2'b00,16'd0)};
    tbl[5] = '{"fault_exit",     1'b1, 1'b0, 1'b0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'd0)};
    tbl[6] = '{"accept_hi",      1'b1, 1'b1, 1'b0, 2'b01, 2'b01, mk(0,0,1,1,0,2'b01,16'd1)};
    foreach (tbl[i]) cyc(tbl[i].name, tbl[i].rst, tbl[i].en, tbl[i].flt, tbl[i].req, tbl[i].sig, tbl[i].exp);

    // Basic jump: 10 dead cycles total, 20 high cycles, then jump to low.
    repeat (9)  cyc("dead_to_hi", 1, 1, 0, 2'b01, 2'b00, mk(0,0,1,1,0,2'b00,16'd1));
    repeat (20) cyc("dwell_hi",   1, 1, 0, 2'b01, 2'b00, mk(1,0,1,0,0,2'b00,16'd1));
    cyc("jump_to_lo", 1, 1, 0, 2'b01, 2'b00, mk(0,0,0,1,0,2'b01,16'd2));
    repeat (9)  cyc("dead_to_lo", 1, 1, 0, 2'b01, 2'b00, mk(0,0,0,1,0,2'b00,16'd2));

    // Priority: requester 0 wins with target equal to the held state.
    repeat (23) cyc("prio_same_target", 1, 1, 0, 2'b11, 2'b10, mk(0,1,0,0,0,2'b00,16'd2));
    cyc("prio_req1_grant", 1, 1, 0, 2'b10, 2'b10, mk(0,0,1,1,0,2'b10,16'd3));
    repeat (9)  cyc("dead_to_hi_2", 1, 1, 0, 2'b00, 2'b00, mk(0,0,1,1,0,2'b00,16'd3));

    // Chatter: target toggles every 3 cycles from ON_HI entry (k=0); dwell
    // saturates for k>=20 but target is 1 until k=21.
    for (int k = 0; k <= 21; k++) begin
      logic [1:0] s;
      s = {1'b0, ((k / 3) % 2 == 1) ? 1'b0 : 1'b1};
      if (k < 21) cyc("chatter_hold", 1, 1, 0, 2'b01, s, mk(1,0,1,0,0,2'b00,16'd3));
      else        cyc("chatter_jump", 1, 1, 0, 2'b01, s, mk(0,0,0,1,0,2'b01,16'd4));
    end

    // Fault in DEAD_TO_LO with a simultaneous request.
    repeat (2) cyc("dead_before_fault", 1, 1, 0, 2'b00, 2'b00, mk(0,0,0,1,0,2'b00,16'd4));
    cyc("fault_in_dead", 1, 1, 1, 2'b01, 2'b01, mk(0,0,0,0,1,2'b00,16'd4));
    repeat (3) cyc("fault_stay_en", 1, 1, 0, 2'b01, 2'b01, mk(0,0,0,0,1,2'b00,16'd4));
    cyc("fault_to_idle", 1, 0, 0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'd4));

    // Shutdown mid-dead holds sigma; the next dead period restarts from zero.
    cyc("idle_accept_hi", 1, 1, 0, 2'b01, 2'b01, mk(0,0,1,1,0,2'b01,16'd5));
    repeat (4) cyc("dead_partial", 1, 1, 0, 2'b00, 2'b00, mk(0,0,1,1,0,2'b00,16'd5));
    cyc("shutdown_dead", 1, 0, 0, 2'b01, 2'b01, mk(0,0,1,0,0,2'b00,16'd5));
    cyc("reaccept_lo", 1, 1, 0, 2'b01, 2'b00, mk(0,0,0,1,0,2'b01,16'd6));
    repeat (9) cyc("dead_fresh", 1, 1, 0, 2'b00, 2'b00, mk(0,0,0,1,0,2'b00,16'd6));
    repeat (5) cyc("on_lo_partial", 1, 1, 0, 2'b00, 2'b00, mk(0,1,0,0,0,2'b00,16'd6));
    cyc("shutdown_dwell", 1, 0, 0, 2'b01, 2'b01, mk(0,0,0,0,0,2'b00,16'd6));

    // Reset while ON_HI clears everything.
    cyc("accept_pre_reset", 1, 1, 0, 2'b01, 2'b01, mk(0,0,1,1,0,2'b01,16'd7));
    repeat (9) cyc("dead_pre_reset", 1, 1, 0, 2'b00, 2'b00, mk(0,0,1,1,0,2'b00,16'd7));
    repeat (3) cyc("on_hi_pre_reset", 1, 1, 0, 2'b00, 2'b00, mk(1,0,1,0,0,2'b00,16'd7));
    cyc("reset_mid_on", 0, 1, 0, 2'b01, 2'b00, mk(0,0,0,0,0,2'b00,16'd0));
    cyc("after_reset", 1, 0, 0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'd0));

    // Counter wrap: preload 0xFFFF, next accepted jump reads 0.
    force dut.jump_cnt_q = 16'hFFFF;
    #1;
    release dut.jump_cnt_q;
    cyc("preload_hold", 1, 0, 0, 2'b00, 2'b00, mk(0,0,0,0,0,2'b00,16'hFFFF));
    cyc("wrap_accept", 1, 1, 0, 2'b01, 2'b01, mk(0,0,1,1,0,2'b01,16'h0000));
    repeat (2) cyc("wrap_dead", 1, 1, 0, 2'b00, 2'b00, mk(0,0,1,1,0,2'b00,16'h0000));

    n_total++;
    if (!overlap) n_pass++;
    else $display("FAIL gate_overlap: got both gates high, expected never");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hybrid_jump_sequencer.md
Name: hybrid_jump_sequencer

Overview:
Sequences the half-bridge gate pair of the resonant converter from the regularized jump requests (sigma) produced upstream by the regularization stage.
- Arbitrates between N requesters (hybrid controller, startup ramp, manual override) with fixed priority.
- Enforces a dead time between complementary gates and a minimum dwell time in each switch state.
- Handles enable and fault shutdown.
- Sits between the regularization outputs and the gate-driver output pins.

Parameters:
DEAD_TIME, 10, cycles both gates are held low on every transition (legal range 1 to 2^16-1).
MIN_DWELL, 20, minimum cycles a gate stays asserted before a new jump is accepted (legal range 1 to 2^16-1).
N, 2, number of requesters (legal range 1 to 8).

Ports:
i_clk  input  1  system clock.
i_reset  input  1  synchronous, active-low reset; sampled on the rising edge of i_clk.
i_enable  input  1  run enable; low forces shutdown.
i_fault  input  1  overcurrent/protection fault, level-sensitive.
i_req  input  N  per-requester request valid.
i_sigma  input  N  per-requester desired switch state (1 = high-side on, 0 = low-side on).
o_gate_hi  output  1  high-side gate, registered.
o_gate_lo  output  1  low-side gate, registered.
o_sigma  output  1  current committed switch state, registered.
o_busy  output  1  high while in a DEAD state, registered.
o_grant  output  N  one-hot, one-cycle pulse marking the accepted requester, registered.
o_fault_latched  output  1  high while in FAULT, registered.
o_jump_count  output  16  count of accepted jumps; wraps 0xFFFF to 0.

Behaviour:
- Reset (i_reset=0 at a clock edge): state=IDLE, all outputs 0, counters 0. Reset overrides everything, including in mid-DEAD or FAULT.
- States: IDLE, DEAD_TO_HI, DEAD_TO_LO, ON_HI, ON_LO, FAULT.
- Gate outputs by state:
  - ON_HI: o_gate_hi=1, o_gate_lo=0.
  - ON_LO: o_gate_lo=1, o_gate_hi=0.
  - All other states: both gates 0.
  - o_gate_hi and o_gate_lo are never both 1 in any cycle.
- Arbitration: the winner is the lowest index i with i_req[i]=1. Its i_sigma[i] is the target. Requests arriving while no acceptance is possible are dropped, not queued.
- Acceptance conditions:
  - IDLE: i_enable=1 and any request present.
  - ON_x: i_enable=1, dwell_cnt==MIN_DWELL, and target != o_sigma.
  - A request whose target equals o_sigma is ignored: no grant, no count.
- On acceptance, in the same edge:
  - o_grant pulses one cycle.
  - o_jump_count increments.
  - o_sigma takes the target.
  - State moves to DEAD_TO_HI or DEAD_TO_LO; dead_cnt=0, o_busy=1.
- DEAD_x:
  - dead_cnt increments each cycle.
  - When dead_cnt==DEAD_TIME-1, the next state is ON_x, so both gates are low for exactly DEAD_TIME cycles.
  - Requests are ignored.
- ON_x:
  - On entry, dwell_cnt=1.
  - dwell_cnt increments, saturating at MIN_DWELL.
  - Consequence: minimum gate-on width is exactly MIN_DWELL cycles; the earliest new DEAD state begins at cycle MIN_DWELL+1 after entry.
- Shutdown:
  - i_enable=0 in any non-FAULT state: next state is IDLE, gates 0, o_sigma held, counters cleared.
  - This takes effect on the next edge, even mid-DEAD or mid-dwell.
- Fault:
  - i_fault=1 in any state: next state is FAULT, gates 0, o_fault_latched=1.
  - Fault has priority over enable and over requests arriving in the same cycle; no grant is issued that cycle.
- FAULT exit: only when i_fault=0 and i_enable=0, then to IDLE. Re-enabling requires a fresh request.
- Width rules: dead_cnt and dwell_cnt are 16 bits, unsigned. o_jump_count is 16-bit modulo.

Decomposition:
- Package hybrid_pkg holds:
  - state enum seq_state_t (3-bit encoding);
  - CNT_W=16;
  - GATE_OFF/HI/LO constants.
- Sub-module jump_arbiter (combinational fixed-priority, N-wide) outputs grant_onehot, any_req and target_sigma. The sequencer FSM and counters stay in the top module.

Test Plan:
- Reset mid-operation: drive to ON_HI, then hold i_reset=0 for 1 edge -> next cycle all outputs 0, state IDLE, o_jump_count=0.
- Basic jump, DEAD_TIME=10, MIN_DWELL=20: from IDLE, i_req=01 and i_sigma=01 -> o_grant=01 for 1 cycle, both gates low for 10 cycles, then o_gate_hi=1. A request for sigma=0 held continuously -> o_gate_hi stays high exactly 20 cycles, then 10 dead cycles, then o_gate_lo=1. o_jump_count=2.
- Priority: i_req=11, i_sigma=10 while ON_LO with dwell saturated -> requester 0 wins (target 0 = current) -> no grant, no transition. Drop req[0] -> grant=10 and transition to high.
- Chatter rejection: toggle request target every 3 cycles during ON_HI -> no jump before 20 cycles. The first acceptance occurs at the first cycle with dwell saturated and target=0.
- Fault during DEAD_TO_LO with a simultaneous request -> FAULT next cycle, gates 0, no grant. Release i_fault while i_enable=1 -> stays FAULT. Drop i_enable -> IDLE.
- Counter wrap: preload 65535 accepted jumps (or force counter) -> the next accepted jump makes o_jump_count read 0. Over the whole run, the assertion that o_gate_hi and o_gate_lo are never both 1 holds.
